// File: rtl/ml_buf_pkg.sv
// ml_buf_pkg
//   Shared types and default constants for the ping-pong input buffer.
//   - wr_state_t : writer FSM state encoding
//   - DEF_*      : default widths / frame length used as module parameter defaults
//   - NUM_BANKS  : number of buffer banks (ping-pong)
package ml_buf_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_FRAME_LEN  = 784;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int NUM_BANKS      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } wr_state_t;

endpackage

// File: rtl/ibw_bank_status.sv
// ibw_bank_status
//   Per-bank "holds a complete frame" flags for the input buffer.
//   Ports:
//     clk, rst_n   : clock, async active-low reset
//     set_pulse    : one-cycle request to mark set_bank as ready
//     set_bank     : bank selected by set_pulse
//     rel_vec      : per-bank release pulses from the reader
//     frame_ready  : per-bank ready flags
module ibw_bank_status
    import ml_buf_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_pulse,
    input  logic                 set_bank,
    input  logic [NUM_BANKS-1:0] rel_vec,
    output logic [NUM_BANKS-1:0] frame_ready
);

    logic [NUM_BANKS-1:0] set_vec;

    always_comb begin
        set_vec           = '0;
        set_vec[set_bank] = set_pulse;
    end

    // Release is applied before set so that a release of a bank that is not
    // ready can never cancel a set arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_ready <= '0;
        end else begin
            frame_ready <= (frame_ready & ~rel_vec) | set_vec;
        end
    end

endmodule

// File: rtl/input_buffer_writer.sv
// input_buffer_writer
//   Write-side controller of the ping-pong input buffer. Takes a valid/ready
//   sample stream and writes each frame into the free bank, then flags the
//   bank ready until the reader releases it.
//   Ports:
//     clk, rst_n          : clock, async active-low reset
//     s_valid/s_data/s_last/s_ready : loader sample stream
//     wr_en/wr_bank/wr_addr/wr_data : buffer RAM write port (one cycle after the beat)
//     frame_ready         : per-bank complete-frame flags
//     frame_release       : per-bank consumed pulses from the reader
//     frame_err           : one-cycle pulse on a short or long frame
//     frame_count         : committed frames, wrapping
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for the fill bank to be free; s_ready low
//   FILL  | writing samples of the current frame into the fill bank
//   DRAIN | frame was too long: swallow samples up to s_last, no writes
module input_buffer_writer
    import ml_buf_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic                  wr_bank,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [1:0]            frame_ready,
    input  logic [1:0]            frame_release,
    output logic                  frame_err,
    output logic [CNT_WIDTH-1:0]  frame_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);

    wr_state_t             state;
    wr_state_t             state_nxt;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  fill_bank;
    logic                  beat;
    logic                  fill_beat;
    logic                  at_last;
    logic                  commit_d1;
    logic                  set_pulse;
    logic                  set_bank;

    assign beat      = s_valid && s_ready;
    assign fill_beat = beat && (state == FILL);
    assign at_last   = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!frame_ready[fill_bank]) state_nxt = FILL;
            end
            FILL: begin
                if (beat) begin
                    if (s_last)       state_nxt = IDLE;
                    else if (at_last) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (beat && s_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state == FILL) || (state == DRAIN);
    end

    // Commit is delayed two edges after the final beat: one edge for the
    // write itself to reach the RAM, one more so the ready flag rises only
    // after that write has landed. wr_bank still names the committed bank
    // in the cycle commit_d1 is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en       <= 1'b0;
            wr_bank     <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_err   <= 1'b0;
            commit_d1   <= 1'b0;
            set_pulse   <= 1'b0;
            set_bank    <= 1'b0;
            idx         <= '0;
            fill_bank   <= 1'b0;
            frame_count <= '0;
        end else begin
            wr_en     <= fill_beat;
            // Short frame: s_last before the final offset. Long frame: final
            // offset reached without s_last. Either way the two disagree.
            frame_err <= fill_beat && (s_last != at_last);
            commit_d1 <= fill_beat && at_last;
            set_pulse <= commit_d1;
            set_bank  <= wr_bank;

            if (fill_beat) begin
                wr_bank <= fill_bank;
                wr_addr <= idx;
                wr_data <= s_data;
                if (at_last) begin
                    fill_bank <= ~fill_bank;
                    idx       <= '0;
                end else if (s_last) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end

            if (set_pulse) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

    ibw_bank_status u_bank_status (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_pulse   (set_pulse),
        .set_bank    (set_bank),
        .rel_vec     (frame_release),
        .frame_ready (frame_ready)
    );

endmodule
